inst_fetch: RTL and testbench

Instruction-fetch front end that produces the instruction stream consumed by the pipeline's decode stage: owns the program counter, a 256×32 synchronous instruction memory with a loader write port, and a 2-entry prefetch FIFO. It presents one instruction plus its PC per cycle under a valid/ready handshake and accepts branch/jump redirects from later stages.

---
 rtl/inst_fetch_pkg.sv | 18 +
 rtl/imem_sp_256x32.sv | 29 ++
 rtl/inst_fetch.sv | 112 +++++++++++
 tb/tb_inst_fetch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
//   RESET_PC      : first PC fetched after reset
//   NOP_INST      : instruction word presented while no instruction is valid
//   IMEM_AW/DEPTH : instruction-memory word-address width and depth
//   fetch_entry_t : one prefetch-FIFO slot (instruction plus its PC)
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int          IMEM_AW    = 8;
    localparam int          IMEM_DEPTH = 1 << IMEM_AW;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/imem_sp_256x32.sv
// 256x32 instruction memory: one synchronous read port, one write port.
//   clk   : clock
//   we    : write enable (write lands at end of cycle)
//   waddr : write word address
//   wdata : write data
//   raddr : read word address
//   rdata : registered read data, valid the cycle after raddr is presented
// A read and write to the same address in one cycle returns the old word.
module imem_sp_256x32
    import inst_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [IMEM_AW-1:0] waddr,
    input  logic [31:0]        wdata,
    input  logic [IMEM_AW-1:0] raddr,
    output logic [31:0]        rdata
);

    logic [31:0] mem [IMEM_DEPTH];

    // Non-blocking read and write in one process give read-old-on-collision.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC, instruction memory, 2-entry prefetch FIFO.
//   clk, rst               : clock, synchronous active-high reset
//   load_we/addr/data      : loader write port into instruction memory
//   redirect_valid/pc      : branch/jump redirect from later stages
//   inst_ready             : decode accepts the head instruction
//   inst_valid/inst/inst_pc: head of the prefetch FIFO (NOP / 0 when empty)
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_we,
    input  logic [IMEM_AW-1:0] load_addr,
    input  logic [31:0]        load_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               inst_ready,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc
);

    logic [31:0]  pc;
    logic [31:0]  fetch_addr;
    logic [31:0]  rd_data;
    logic         inflight;
    logic [31:0]  inflight_pc;
    logic [1:0]   count, count_n;
    fetch_entry_t ent0, ent1, ent0_n, ent1_n;
    fetch_entry_t push_ent;
    logic         pop, push, issue;
    logic [2:0]   occ;

    assign fetch_addr = redirect_valid ? (redirect_pc & ~32'h3) : pc;

    imem_sp_256x32 u_imem (
        .clk   (clk),
        .we    (load_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (fetch_addr[IMEM_AW+1:2]),
        .rdata (rd_data)
    );

    assign inst_valid = (count != 2'd0);
    assign inst       = inst_valid ? ent0.inst : NOP_INST;
    assign inst_pc    = inst_valid ? ent0.pc   : 32'h0;

    assign pop  = inst_valid & inst_ready;
    // Returning data is dropped when a redirect lands in its return cycle.
    assign push = inflight & ~redirect_valid;
    assign push_ent = '{pc: inflight_pc, inst: rd_data};

    // Occupancy after this cycle counting the in-flight read; pop implies
    // count >= 1 so this never underflows. Keeping it below 2 means the
    // FIFO cannot overflow when the issued word returns.
    assign occ   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign issue = redirect_valid | (occ < 3'd2);

    always_comb begin
        count_n = count;
        ent0_n  = ent0;
        ent1_n  = ent1;
        if (redirect_valid) begin
            count_n = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0_n = push_ent;
                    else               ent1_n = push_ent;
                    count_n = count + 2'd1;
                end
                2'b01: begin
                    ent0_n  = ent1;
                    count_n = count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0_n = push_ent;
                    end else begin
                        ent0_n = ent1;
                        ent1_n = push_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            count       <= 2'd0;
        end else begin
            inflight <= issue;
            count    <= count_n;
            if (issue) begin
                pc          <= fetch_addr + 32'd4;
                inflight_pc <= fetch_addr;
            end
        end
    end

    // FIFO payload needs no reset: it is qualified by count.
    always_ff @(posedge clk) begin
        ent0 <= ent0_n;
        ent1 <= ent1_n;
    end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_we = 1'b0;
    logic [7:0]  load_addr = 8'h0;
    logic [31:0] load_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_ready     (inst_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    exp_t        q[$];
    logic [31:0] mem_model [256];
    vec_t        vecs [5];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p = start + 32'(4 * i);
            q.push_back('{pc: p, inst: mem_model[p[9:2]]});
        end
    endtask

    // Scoreboard: every accepted instruction must match the next expectation.
    task automatic mon();
        exp_t e;
        if (inst_valid && inst_ready && !redirect_valid && !rst) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty actual pc=%h required none", inst_pc);
            end else begin
                e = q.pop_front();
                chk("sb_pc", inst_pc, e.pc);
                chk("sb_inst", inst, e.inst);
            end
        end
    endtask

    task automatic obs();
        @(negedge clk);
        mon();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{rpc: 32'h40,        exp_pc: 32'h40,        exp_inst: 32'hB0};
        vecs[1] = '{rpc: 32'h3FC,       exp_pc: 32'h3FC,       exp_inst: 32'h19F};
        vecs[2] = '{rpc: 32'h43,        exp_pc: 32'h40,        exp_inst: 32'hB0};
        vecs[3] = '{rpc: 32'hFFFF_FFFC, exp_pc: 32'hFFFF_FFFC, exp_inst: 32'h19F};
        vecs[4] = '{rpc: 32'h104,       exp_pc: 32'h104,       exp_inst: 32'hE1};

        // Load memory while held in reset.
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            load_we      = 1'b1;
            load_addr    = 8'(i);
            load_data    = 32'hA0 + 32'(i);
            mem_model[i] = load_data;
            adv();
        end
        load_we = 1'b0;
        obs();
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst", inst, 32'h13);
        chk("rst_pc", inst_pc, 32'h0);

        // Release: cycle 0.
        adv();
        rst = 1'b0;
        inst_ready = 1'b1;
        q.delete();
        push_stream(32'h0, 64);
        obs();
        chk("rel_c0_valid", 32'(inst_valid), 32'h0);
        adv();
        obs();
        chk("rel_c1_valid", 32'(inst_valid), 32'h0);
        for (int c = 2; c <= 5; c++) begin
            adv();
            obs();
            chk("rel_stream_valid", 32'(inst_valid), 32'h1);
            chk("rel_stream_pc", inst_pc, 32'(4 * (c - 2)));
        end

        // Stall: head must hold steady.
        adv();
        inst_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            obs();
            chk("stall_valid", 32'(inst_valid), 32'h1);
            chk("stall_pc", inst_pc, q[0].pc);
            chk("stall_inst", inst, q[0].inst);
            adv();
        end
        inst_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            obs();
            chk("resume_valid", 32'(inst_valid), 32'h1);
            adv();
        end

        // Redirect vectors.
        for (int v = 0; v < 5; v++) begin
            redirect_valid = 1'b1;
            redirect_pc    = vecs[v].rpc;
            obs();
            q.delete();
            push_stream(vecs[v].exp_pc, 8);
            adv();
            redirect_valid = 1'b0;
            obs();
            chk("redir_gap_valid", 32'(inst_valid), 32'h0);
            adv();
            obs();
            chk("redir_valid", 32'(inst_valid), 32'h1);
            chk("redir_pc", inst_pc, vecs[v].exp_pc);
            chk("redir_inst", inst, vecs[v].exp_inst);
            for (int c = 0; c < 3; c++) begin
                adv();
                obs();
            end
            adv();
        end

        // Loader write colliding with fetch of the same word.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        load_we        = 1'b1;
        load_addr      = 8'd5;
        load_data      = 32'hDEAD_BEEF;
        obs();
        q.delete();
        push_stream(32'h14, 8);
        mem_model[5] = 32'hDEAD_BEEF;
        adv();
        redirect_valid = 1'b0;
        load_we        = 1'b0;
        obs();
        adv();
        obs();
        chk("coll_old_pc", inst_pc, 32'h14);
        chk("coll_old_inst", inst, 32'hA5);
        adv();
        obs();
        adv();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        obs();
        q.delete();
        push_stream(32'h14, 8);
        adv();
        redirect_valid = 1'b0;
        obs();
        adv();
        obs();
        chk("coll_new_inst", inst, 32'hDEAD_BEEF);
        adv();

        // Reset mid-stream with the FIFO full.
        inst_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            obs();
            adv();
        end
        rst = 1'b1;
        inst_ready = 1'b1;
        obs();
        adv();
        rst = 1'b0;
        q.delete();
        push_stream(32'h0, 8);
        obs();
        chk("mrst_valid", 32'(inst_valid), 32'h0);
        chk("mrst_inst", inst, 32'h13);
        chk("mrst_pc", inst_pc, 32'h0);
        adv();
        obs();
        chk("mrst_c1_valid", 32'(inst_valid), 32'h0);
        adv();
        obs();
        chk("mrst_c2_valid", 32'(inst_valid), 32'h1);
        chk("mrst_c2_pc", inst_pc, 32'h0);
        adv();
        obs();
        adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
